// File: rtl/l_link_pkg.sv
// l_link_pkg: shared link states, line levels and frame sizing for bus-bit drivers.
package l_link_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  function automatic int frame_len(input int data_w, input int parity_en, input int clks_per_bit);
    return (2 + data_w + parity_en) * clks_per_bit;
  endfunction
endpackage

// File: rtl/l_bit_timer.sv
// l_bit_timer: counts CLKS_PER_BIT cycles per bit period and flags the last one.
module l_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_bit_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_restart) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  assign o_bit_done = r_cnt == CW'(CLKS_PER_BIT - 1);
endmodule

// File: rtl/l_driver.sv
// l_driver: serializes a payload word onto one tristate bus bit as start/data/parity/stop.
module l_driver
  import l_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              lane,
  output logic              lane_oe,
  output logic              busy
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit;
  logic              r_lane;
  logic              r_oe;
  logic              r_ready;
  logic              w_done;
  logic              w_restart;
  // timer free-runs from zero each time a bit period begins
  assign w_restart = (r_state == IDLE) || w_done;
  l_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_bit_done(w_done)
  );
  assign lane     = r_oe ? r_lane : 1'bz;
  assign lane_oe  = r_oe;
  assign busy     = r_state != IDLE;
  assign tx_ready = r_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_lane  <= STOP_LVL;
      r_oe    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (tx_valid && r_ready) begin
            r_data  <= tx_data;
            r_shift <= tx_data;
            r_state <= START;
            r_lane  <= START_LVL;
            r_oe    <= 1'b1;
            r_ready <= 1'b0;
          end else r_ready <= 1'b1;
        START:
          if (w_done) begin
            r_state <= DATA;
            r_lane  <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
          end
        DATA:
          if (w_done) begin
            if (r_bit == BW'(DATA_W - 1)) begin
              r_state <= PARITY_EN != 0 ? PARITY : STOP;
              r_lane  <= PARITY_EN != 0 ? ^r_data : STOP_LVL;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_lane  <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        PARITY:
          if (w_done) begin
            r_state <= STOP;
            r_lane  <= STOP_LVL;
          end
        STOP:
          if (w_done) begin
            r_state <= IDLE;
            r_oe    <= 1'b0;
            r_ready <= 1'b1;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l_driver.sv
// tb_l_driver: three configurations driven with random and directed words, scoreboarded per lane.
module tb_l_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int passed = 0;

  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
  endtask

  task automatic chkn(input string n, input int a, input int e);
    checks++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen
    localparam int CPB = g == 2 ? 1 : (g == 1 ? 2 : 4);
    localparam int PE  = g == 1 ? 0 : 1;
    localparam int LEN = (10 + PE) * CPB;
    logic       rst = 1'b1;
    logic       rs  = 1'b1;
    logic       v   = 1'b0;
    logic [7:0] d   = 8'h00;
    wire        ready, lane, oe, busy;
    logic [7:0] q[$];
    logic [7:0] w = 8'h00;
    int         pos = -1;
    bit         done = 1'b0;

    l_driver #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(PE)) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (d),
      .tx_valid(v),
      .tx_ready(ready),
      .lane    (lane),
      .lane_oe (oe),
      .busy    (busy)
    );

    // expected lane level for bit period b of a frame carrying x
    function automatic logic exp_bit(input logic [7:0] x, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return x[b-1];
      if (b == 9 && PE == 1) return ^x;
      return 1'b1;
    endfunction

    always @(posedge clk) rs <= rst;

    always @(negedge clk) begin
      if (rs) begin
        pos = -1;
        chk("reset_oe", oe, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", ready, 1'b0);
      end else if (oe) begin
        if (pos < 0) begin
          chk("frame_expected", q.size() != 0, 1'b1);
          w = q.size() != 0 ? q.pop_front() : 8'h00;
          pos = 0;
        end
        if (pos < LEN) chk("lane_bit", lane, exp_bit(w, pos / CPB));
        else chk("frame_overrun", oe, 1'b0);
        chk("busy_frame", busy, 1'b1);
        chk("ready_frame", ready, 1'b0);
        pos++;
      end else begin
        if (pos >= 0) chkn("frame_len", pos, LEN);
        pos = -1;
        chk("idle_busy", busy, 1'b0);
      end
    end

    task automatic wait_ready();
      int t = 0;
      while (!ready && t < 300) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("ready_timeout", ready, 1'b1);
    endtask

    task automatic send(input logic [7:0] x);
      wait_ready();
      d = x;
      v = 1'b1;
      q.push_back(x);
      @(posedge clk);
      #1;
      v = 1'b0;
      d = 8'($urandom);
    endtask

    initial begin
      int t;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("release_ready", ready, 1'b1);
      chk("release_oe", oe, 1'b0);
      chk("release_busy", busy, 1'b0);
      send(8'hA5);
      send(8'h07);
      send(8'hFF);
      send(8'h5A);
      d = 8'h3C;
      v = 1'b1;
      wait_ready();
      q.push_back(8'h3C);
      @(posedge clk);
      #1 v = 1'b0;
      repeat (6) send(8'($urandom));
      send(8'hC3);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      chk("abort_oe", oe, 1'b0);
      chk("abort_busy", busy, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      send(8'h96);
      send(8'($urandom));
      t = 0;
      while ((q.size() != 0 || pos >= 0) && t < 500) begin
        @(posedge clk);
        t++;
      end
      chk("drained", q.size() == 0 && pos < 0, 1'b1);
      done = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(gen[0].done && gen[1].done && gen[2].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("all_done", gen[0].done && gen[1].done && gen[2].done, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
